// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage: opcodes, ALU/writeback/next-PC codes,
// instruction field positions and the operand forwarding priority helper.
package id_stage_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_OR   = 5'd2;
  localparam logic [4:0] OP_NOR  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_ORI  = 5'd6;
  localparam logic [4:0] OP_NORI = 5'd7;
  localparam logic [4:0] OP_ANDI = 5'd8;
  localparam logic [4:0] OP_LW   = 5'd9;
  localparam logic [4:0] OP_SW   = 5'd10;
  localparam logic [4:0] OP_J    = 5'd11;
  localparam logic [4:0] OP_CALL = 5'd12;
  localparam logic [4:0] OP_JR   = 5'd13;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_NOR = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_NPC = 2'b10;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_OFF = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  localparam int OP_HI = 31, OP_LO = 27;
  localparam int RP_HI = 26, RP_LO = 22;
  localparam int RD_HI = 21, RD_LO = 17;
  localparam int RS_HI = 16, RS_LO = 12;
  localparam int RT_HI = 11, RT_LO = 7;
  localparam int IMM_W = 12;
  localparam int OFF_W = 22;

  localparam logic [4:0] LINK_REG = 5'd31;

  // Index 0 = EX, 1 = MEM, 2 = WB; the youngest producer wins.
  function automatic logic [31:0] fwd_sel(input logic [4:0] src, input logic [31:0] rf_val,
                                          input logic [2:0] we, input logic [2:0] rpz,
                                          input logic [2:0][4:0] rd, input logic [2:0][31:0] val);
    logic [31:0] r;
    r = rf_val;
    for (int i = 2; i >= 0; i--)
      if (we[i] && !rpz[i] && rd[i] != 5'd0 && rd[i] == src) r = val[i];
    return r;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two operand read ports plus a predicate port, R0 hardwired
// to zero, and write-through so a same-cycle read of the written register sees new data.
module id_regfile
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra_a,
  input  logic [4:0]  ra_b,
  input  logic [4:0]  ra_p,
  output logic [31:0] rd_a,
  output logic [31:0] rd_b,
  output logic [31:0] rd_p
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  function automatic logic [31:0] rd_port(input logic [4:0] ra, input logic [31:0] stored,
                                          input logic w, input logic [4:0] a, input logic [31:0] d);
    if (ra == 5'd0)          return '0;
    else if (w && a == ra)   return d;
    else                     return stored;
  endfunction

  assign rd_a = rd_port(ra_a, regs[ra_a], we, wa, wd);
  assign rd_b = rd_port(ra_b, regs[ra_b], we, wa, wd);
  assign rd_p = rd_port(ra_p, regs[ra_p], we, wa, wd);

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decode, register read with forwarding, predicate
// evaluation, load-use interlock, next-PC selection and the ID/EX pipeline register.
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instruction_D,
  input  logic [31:0] NPC_D,
  input  logic        RegWr_WB_final,
  input  logic [4:0]  Rd_WB,
  input  logic [31:0] BusW_WB,
  input  logic [31:0] Fwd_EX,
  input  logic [31:0] Fwd_MEM,
  input  logic [31:0] Fwd_WB,
  input  logic [4:0]  Rd_EX,
  input  logic [4:0]  Rd_MEM,
  input  logic [4:0]  Rd_WB_pipe,
  input  logic        RegWrite_EX,
  input  logic        RegWrite_MEM,
  input  logic        RegWrite_WB,
  input  logic        MemRead_EX,
  input  logic        RPzero_EX,
  input  logic        RPzero_MEM,
  input  logic        RPzero_WB,
  output logic [1:0]  PCsrc,
  output logic        KILL,
  output logic [31:0] PC_offset,
  output logic [31:0] PC_regRs,
  output logic        Stall,
  output logic        disable_PC,
  output logic        disable_IR,
  output logic        RegWr_final,
  output logic        MemWr_final,
  output logic        MemRd_final,
  output logic        RegWr_IDEX,
  output logic        MemWr_IDEX,
  output logic        MemRd_IDEX,
  output logic        ALUSrc_IDEX,
  output logic [2:0]  ALUop_IDEX,
  output logic [1:0]  WBdata_IDEX,
  output logic [31:0] A_IDEX,
  output logic [31:0] B_IDEX,
  output logic [31:0] IMM_IDEX,
  output logic [31:0] NPC2_IDEX,
  output logic [4:0]  Rd2_IDEX,
  output logic        RPzero_IDEX
);

  logic [4:0] op, rp, rd, rs, rt, b_src;
  logic [IMM_W-1:0] imm12;
  logic [OFF_W-1:0] off22;

  assign op    = Instruction_D[OP_HI:OP_LO];
  assign rp    = Instruction_D[RP_HI:RP_LO];
  assign rd    = Instruction_D[RD_HI:RD_LO];
  assign rs    = Instruction_D[RS_HI:RS_LO];
  assign rt    = Instruction_D[RT_HI:RT_LO];
  assign imm12 = Instruction_D[IMM_W-1:0];
  assign off22 = Instruction_D[OFF_W-1:0];

  logic       dec_regwr, dec_memwr, dec_memrd, dec_alusrc, dec_sext;
  logic       use_rs, use_b, is_store, is_br, is_jr, is_call;
  logic [2:0] dec_aluop;
  logic [1:0] dec_wb;

  always_comb begin
    dec_regwr = 1'b0; dec_memwr = 1'b0; dec_memrd = 1'b0; dec_alusrc = 1'b0;
    dec_sext  = 1'b1; use_rs = 1'b0; use_b = 1'b0; is_store = 1'b0;
    is_br = 1'b0; is_jr = 1'b0; is_call = 1'b0;
    dec_aluop = ALU_ADD; dec_wb = WB_ALU;
    case (op)
      OP_ADD:  begin dec_regwr = 1'b1; use_rs = 1'b1; use_b = 1'b1; dec_aluop = ALU_ADD; end
      OP_SUB:  begin dec_regwr = 1'b1; use_rs = 1'b1; use_b = 1'b1; dec_aluop = ALU_SUB; end
      OP_OR:   begin dec_regwr = 1'b1; use_rs = 1'b1; use_b = 1'b1; dec_aluop = ALU_OR;  end
      OP_NOR:  begin dec_regwr = 1'b1; use_rs = 1'b1; use_b = 1'b1; dec_aluop = ALU_NOR; end
      OP_AND:  begin dec_regwr = 1'b1; use_rs = 1'b1; use_b = 1'b1; dec_aluop = ALU_AND; end
      OP_ADDI: begin dec_regwr = 1'b1; use_rs = 1'b1; dec_alusrc = 1'b1; dec_aluop = ALU_ADD; end
      OP_ORI:  begin dec_regwr = 1'b1; use_rs = 1'b1; dec_alusrc = 1'b1; dec_aluop = ALU_OR;  dec_sext = 1'b0; end
      OP_NORI: begin dec_regwr = 1'b1; use_rs = 1'b1; dec_alusrc = 1'b1; dec_aluop = ALU_NOR; dec_sext = 1'b0; end
      OP_ANDI: begin dec_regwr = 1'b1; use_rs = 1'b1; dec_alusrc = 1'b1; dec_aluop = ALU_AND; dec_sext = 1'b0; end
      OP_LW:   begin dec_regwr = 1'b1; dec_memrd = 1'b1; use_rs = 1'b1; dec_alusrc = 1'b1; dec_wb = WB_MEM; end
      OP_SW:   begin dec_memwr = 1'b1; use_rs = 1'b1; use_b = 1'b1; is_store = 1'b1; dec_alusrc = 1'b1; end
      OP_J:    is_br = 1'b1;
      OP_CALL: begin is_br = 1'b1; is_call = 1'b1; dec_regwr = 1'b1; dec_wb = WB_NPC; end
      OP_JR:   begin is_jr = 1'b1; use_rs = 1'b1; end
      default: ;
    endcase
  end

  // Stores carry their data register in the Rd field.
  assign b_src = is_store ? rd : rt;

  logic [31:0] rf_a, rf_b, rf_p, a_val, b_val, p_val;

  id_regfile u_rf (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (RegWr_WB_final),
    .wa   (Rd_WB),
    .wd   (BusW_WB),
    .ra_a (rs),
    .ra_b (b_src),
    .ra_p (rp),
    .rd_a (rf_a),
    .rd_b (rf_b),
    .rd_p (rf_p)
  );

  logic [2:0]       fw_we, fw_rpz;
  logic [2:0][4:0]  fw_rd;
  logic [2:0][31:0] fw_val;

  assign fw_we  = {RegWrite_WB, RegWrite_MEM, RegWrite_EX};
  assign fw_rpz = {RPzero_WB, RPzero_MEM, RPzero_EX};
  assign fw_rd  = {Rd_WB_pipe, Rd_MEM, Rd_EX};
  assign fw_val = {Fwd_WB, Fwd_MEM, Fwd_EX};

  assign a_val = fwd_sel(rs,    rf_a, fw_we, fw_rpz, fw_rd, fw_val);
  assign b_val = fwd_sel(b_src, rf_b, fw_we, fw_rpz, fw_rd, fw_val);
  assign p_val = fwd_sel(rp,    rf_p, fw_we, fw_rpz, fw_rd, fw_val);

  logic rpzero, go;
  assign rpzero = (rp != 5'd0) && (p_val == 32'd0);

  // A load in EX cannot forward in time: hold ID if it feeds the predicate or any used operand.
  assign Stall = MemRead_EX && RegWrite_EX && !RPzero_EX && (Rd_EX != 5'd0) &&
                 ((Rd_EX == rp) || (use_rs && Rd_EX == rs) || (use_b && Rd_EX == b_src));
  assign disable_PC = Stall;
  assign disable_IR = Stall;

  assign go          = !rpzero && !Stall;
  assign RegWr_final = dec_regwr && go;
  assign MemWr_final = dec_memwr && go;
  assign MemRd_final = dec_memrd && go;

  assign PCsrc     = (is_br && go) ? PC_OFF : (is_jr && go) ? PC_REG : PC_SEQ;
  assign KILL      = (PCsrc != PC_SEQ);
  assign PC_offset = NPC_D - 32'd1 + {{(32-OFF_W){off22[OFF_W-1]}}, off22};
  assign PC_regRs  = a_val;

  logic [31:0] imm_ext;
  assign imm_ext = dec_sext ? {{(32-IMM_W){imm12[IMM_W-1]}}, imm12} : {{(32-IMM_W){1'b0}}, imm12};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWr_IDEX <= 1'b0; MemWr_IDEX <= 1'b0; MemRd_IDEX <= 1'b0; ALUSrc_IDEX <= 1'b0;
      ALUop_IDEX <= '0;   WBdata_IDEX <= '0;  A_IDEX <= '0;       B_IDEX <= '0;
      IMM_IDEX <= '0;     NPC2_IDEX <= '0;    Rd2_IDEX <= '0;     RPzero_IDEX <= 1'b0;
    end else begin
      RegWr_IDEX  <= RegWr_final;
      MemWr_IDEX  <= MemWr_final;
      MemRd_IDEX  <= MemRd_final;
      ALUSrc_IDEX <= dec_alusrc;
      ALUop_IDEX  <= dec_aluop;
      WBdata_IDEX <= dec_wb;
      A_IDEX      <= a_val;
      B_IDEX      <= b_val;
      IMM_IDEX    <= imm_ext;
      NPC2_IDEX   <= NPC_D;
      Rd2_IDEX    <= is_call ? LINK_REG : rd;
      RPzero_IDEX <= rpzero;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-computed vectors for decode, forwarding,
// predication, load-use interlock, next-PC selection and reset.
module tb_id_stage;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] Instruction_D = '0, NPC_D = '0;
  logic        RegWr_WB_final = 1'b0;
  logic [4:0]  Rd_WB = '0;
  logic [31:0] BusW_WB = '0, Fwd_EX = '0, Fwd_MEM = '0, Fwd_WB = '0;
  logic [4:0]  Rd_EX = '0, Rd_MEM = '0, Rd_WB_pipe = '0;
  logic        RegWrite_EX = 1'b0, RegWrite_MEM = 1'b0, RegWrite_WB = 1'b0, MemRead_EX = 1'b0;
  logic        RPzero_EX = 1'b0, RPzero_MEM = 1'b0, RPzero_WB = 1'b0;
  logic [1:0]  PCsrc, WBdata_IDEX;
  logic        KILL, Stall, disable_PC, disable_IR, RegWr_final, MemWr_final, MemRd_final;
  logic        RegWr_IDEX, MemWr_IDEX, MemRd_IDEX, ALUSrc_IDEX, RPzero_IDEX;
  logic [2:0]  ALUop_IDEX;
  logic [31:0] PC_offset, PC_regRs, A_IDEX, B_IDEX, IMM_IDEX, NPC2_IDEX;
  logic [4:0]  Rd2_IDEX;

  int n_tests = 0, n_fail = 0;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .Instruction_D(Instruction_D), .NPC_D(NPC_D),
    .RegWr_WB_final(RegWr_WB_final), .Rd_WB(Rd_WB), .BusW_WB(BusW_WB),
    .Fwd_EX(Fwd_EX), .Fwd_MEM(Fwd_MEM), .Fwd_WB(Fwd_WB),
    .Rd_EX(Rd_EX), .Rd_MEM(Rd_MEM), .Rd_WB_pipe(Rd_WB_pipe),
    .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
    .MemRead_EX(MemRead_EX), .RPzero_EX(RPzero_EX), .RPzero_MEM(RPzero_MEM), .RPzero_WB(RPzero_WB),
    .PCsrc(PCsrc), .KILL(KILL), .PC_offset(PC_offset), .PC_regRs(PC_regRs),
    .Stall(Stall), .disable_PC(disable_PC), .disable_IR(disable_IR),
    .RegWr_final(RegWr_final), .MemWr_final(MemWr_final), .MemRd_final(MemRd_final),
    .RegWr_IDEX(RegWr_IDEX), .MemWr_IDEX(MemWr_IDEX), .MemRd_IDEX(MemRd_IDEX),
    .ALUSrc_IDEX(ALUSrc_IDEX), .ALUop_IDEX(ALUop_IDEX), .WBdata_IDEX(WBdata_IDEX),
    .A_IDEX(A_IDEX), .B_IDEX(B_IDEX), .IMM_IDEX(IMM_IDEX), .NPC2_IDEX(NPC2_IDEX),
    .Rd2_IDEX(Rd2_IDEX), .RPzero_IDEX(RPzero_IDEX)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RegWr_WB_final = 1'b1; Rd_WB = a; BusW_WB = d;
    tick();
    RegWr_WB_final = 1'b0;
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] op, rp, rd, rs, rt);
    return {op, rp, rd, rs, rt, 7'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] op, rp, rd, rs, input logic [11:0] imm);
    return {op, rp, rd, rs, imm};
  endfunction

  function automatic logic [31:0] mk_j(input logic [4:0] op, rp, input logic [21:0] off);
    return {op, rp, off};
  endfunction

  task automatic clr_haz();
    Rd_EX = '0; Rd_MEM = '0; Rd_WB_pipe = '0;
    RegWrite_EX = 1'b0; RegWrite_MEM = 1'b0; RegWrite_WB = 1'b0; MemRead_EX = 1'b0;
    RPzero_EX = 1'b0; RPzero_MEM = 1'b0; RPzero_WB = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_A", A_IDEX, 32'd0);
    chk("rst_RegWr", 32'(RegWr_IDEX), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;

    wr(5'd1, 32'd5); wr(5'd2, 32'd7); wr(5'd6, 32'd1); wr(5'd0, 32'd9); wr(5'd3, 32'h12345678);

    // ADD Rp=6 Rd=5 Rs=1 Rt=2
    Instruction_D = mk_r(5'd0, 5'd6, 5'd5, 5'd1, 5'd2); NPC_D = 32'd100;
    #1;
    chk("add_regwr_final", 32'(RegWr_final), 32'd1);
    chk("add_stall", 32'(Stall), 32'd0);
    chk("add_pcsrc", 32'(PCsrc), 32'd0);
    tick();
    chk("add_A", A_IDEX, 32'd5);
    chk("add_B", B_IDEX, 32'd7);
    chk("add_regwr", 32'(RegWr_IDEX), 32'd1);
    chk("add_rpzero", 32'(RPzero_IDEX), 32'd0);
    chk("add_alusrc", 32'(ALUSrc_IDEX), 32'd0);
    chk("add_rd2", 32'(Rd2_IDEX), 32'd5);
    chk("add_npc2", NPC2_IDEX, 32'd100);

    // Forwarding priority EX > MEM > WB
    Fwd_EX = 32'hAAAA0001; Fwd_MEM = 32'hBBBB0002; Fwd_WB = 32'hCCCC0003;
    Rd_EX = 5'd1; RegWrite_EX = 1'b1; Rd_MEM = 5'd1; RegWrite_MEM = 1'b1;
    tick();
    chk("fwd_ex", A_IDEX, 32'hAAAA0001);
    chk("fwd_ex_B", B_IDEX, 32'd7);
    RegWrite_EX = 1'b0;
    tick();
    chk("fwd_mem", A_IDEX, 32'hBBBB0002);
    RegWrite_MEM = 1'b0; Rd_WB_pipe = 5'd1; RegWrite_WB = 1'b1;
    tick();
    chk("fwd_wb", A_IDEX, 32'hCCCC0003);
    RPzero_WB = 1'b1;
    tick();
    chk("fwd_wb_squashed", A_IDEX, 32'd5);
    clr_haz();
    Rd_MEM = 5'd2; RegWrite_MEM = 1'b1; Fwd_MEM = 32'hDDDD0004;
    tick();
    chk("fwd_mem_B", B_IDEX, 32'hDDDD0004);
    clr_haz();

    // Load-use interlock
    Rd_EX = 5'd1; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    #1;
    chk("lu_stall", 32'(Stall), 32'd1);
    chk("lu_dis_pc", 32'(disable_PC), 32'd1);
    chk("lu_dis_ir", 32'(disable_IR), 32'd1);
    chk("lu_regwr_final", 32'(RegWr_final), 32'd0);
    tick();
    chk("lu_bubble", 32'(RegWr_IDEX), 32'd0);
    RPzero_EX = 1'b1;
    #1;
    chk("lu_rpz_nostall", 32'(Stall), 32'd0);
    tick();
    chk("lu_rpz_regwr", 32'(RegWr_IDEX), 32'd1);
    clr_haz();
    Rd_EX = 5'd6; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    #1;
    chk("lu_pred_stall", 32'(Stall), 32'd1);
    clr_haz();

    // Predication
    Instruction_D = mk_r(5'd0, 5'd0, 5'd5, 5'd1, 5'd2);
    tick();
    chk("rp0_rpzero", 32'(RPzero_IDEX), 32'd0);
    chk("rp0_regwr", 32'(RegWr_IDEX), 32'd1);
    Instruction_D = mk_r(5'd0, 5'd4, 5'd5, 5'd1, 5'd2);
    #1;
    chk("rp4_regwr_final", 32'(RegWr_final), 32'd0);
    tick();
    chk("rp4_rpzero", 32'(RPzero_IDEX), 32'd1);
    chk("rp4_regwr", 32'(RegWr_IDEX), 32'd0);
    Instruction_D = mk_r(5'd0, 5'd6, 5'd5, 5'd1, 5'd2);
    Rd_EX = 5'd6; RegWrite_EX = 1'b1; Fwd_EX = 32'd0;
    #1;
    chk("pred_fwd_final", 32'(RegWr_final), 32'd0);
    clr_haz();

    // SW: B from Rd field, sign-extended imm
    Instruction_D = mk_i(5'd10, 5'd0, 5'd3, 5'd1, 12'hFF0);
    #1;
    chk("sw_memwr_final", 32'(MemWr_final), 32'd1);
    chk("sw_regwr_final", 32'(RegWr_final), 32'd0);
    tick();
    chk("sw_B", B_IDEX, 32'h12345678);
    chk("sw_imm", IMM_IDEX, 32'hFFFFFFF0);
    chk("sw_memwr", 32'(MemWr_IDEX), 32'd1);
    chk("sw_alusrc", 32'(ALUSrc_IDEX), 32'd1);
    Instruction_D = mk_i(5'd9, 5'd0, 5'd5, 5'd1, 12'h004);
    #1;
    chk("lw_memrd_final", 32'(MemRd_final), 32'd1);
    tick();
    chk("lw_wbdata", 32'(WBdata_IDEX), 32'd1);
    chk("lw_memrd", 32'(MemRd_IDEX), 32'd1);
    Instruction_D = mk_i(5'd6, 5'd0, 5'd5, 5'd1, 12'hFFF);
    tick();
    chk("ori_imm", IMM_IDEX, 32'h00000FFF);
    chk("ori_aluop", 32'(ALUop_IDEX), 32'd2);
    Instruction_D = mk_i(5'd5, 5'd0, 5'd5, 5'd1, 12'hFFF);
    tick();
    chk("addi_imm", IMM_IDEX, 32'hFFFFFFFF);

    // Jumps
    Instruction_D = mk_j(5'd11, 5'd6, 22'd8); NPC_D = 32'd100;
    #1;
    chk("j_pcsrc", 32'(PCsrc), 32'd1);
    chk("j_kill", 32'(KILL), 32'd1);
    chk("j_off", PC_offset, 32'd107);
    Instruction_D = mk_j(5'd11, 5'd4, 22'd8);
    #1;
    chk("j_rpz_pcsrc", 32'(PCsrc), 32'd0);
    chk("j_rpz_kill", 32'(KILL), 32'd0);
    Instruction_D = mk_j(5'd11, 5'd0, 22'h3FFFFE);
    #1;
    chk("j_neg_off", PC_offset, 32'd97);
    Instruction_D = mk_j(5'd12, 5'd6, 22'd8);
    #1;
    chk("call_pcsrc", 32'(PCsrc), 32'd1);
    tick();
    chk("call_rd2", 32'(Rd2_IDEX), 32'd31);
    chk("call_wbdata", 32'(WBdata_IDEX), 32'd2);
    chk("call_npc2", NPC2_IDEX, 32'd100);
    chk("call_regwr", 32'(RegWr_IDEX), 32'd1);
    Instruction_D = mk_j(5'd12, 5'd4, 22'd8);
    tick();
    chk("call_rpz_regwr", 32'(RegWr_IDEX), 32'd0);
    Instruction_D = mk_r(5'd13, 5'd0, 5'd0, 5'd1, 5'd0);
    #1;
    chk("jr_pcsrc", 32'(PCsrc), 32'd2);
    chk("jr_kill", 32'(KILL), 32'd1);
    chk("jr_target", PC_regRs, 32'd5);
    Instruction_D = mk_r(5'd20, 5'd0, 5'd5, 5'd1, 5'd2);
    #1;
    chk("nop_regwr_final", 32'(RegWr_final), 32'd0);
    chk("nop_pcsrc", 32'(PCsrc), 32'd0);

    // Write-through and R0
    Instruction_D = mk_r(5'd13, 5'd0, 5'd0, 5'd1, 5'd0);
    RegWr_WB_final = 1'b1; Rd_WB = 5'd1; BusW_WB = 32'h55;
    #1;
    chk("wt_comb", PC_regRs, 32'h55);
    tick();
    RegWr_WB_final = 1'b0;
    chk("wt_A", A_IDEX, 32'h55);
    Instruction_D = mk_r(5'd0, 5'd0, 5'd5, 5'd0, 5'd1);
    tick();
    chk("r0_A", A_IDEX, 32'd0);
    chk("r1_kept", B_IDEX, 32'h55);

    // Asynchronous reset mid-cycle
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_A", A_IDEX, 32'd0);
    chk("arst_B", B_IDEX, 32'd0);
    chk("arst_npc2", NPC2_IDEX, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
